// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the physics block's btn_* inputs.
// The master side drives the raw pins; the slave side is the conditioner.
interface button_conditioner_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               any_press;

    modport master (output btn_raw, input btn_level, btn_press, btn_release, any_press);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release, any_press);
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, counter debouncer, press/release strobes and hold-to-repeat,
// replicated NUM_BTN times with no interaction between buttons.
module button_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_nxt
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] D_M1  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_M1 = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RP_M1 = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} rstate_t;

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          flip, rise, fall;
    rstate_t       state, state_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          rep_fire, rel_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // flip fires on the D-th consecutive sample that disagrees with the accepted level
    assign flip = (s2 != level) && (cnt == D_M1);
    assign rise = flip && s2;
    assign fall = flip && !s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level || flip) begin
            cnt   <= '0;
            level <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            rcnt  <= rcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        case (state)
            ST_IDLE: begin
                if (rise && REPEAT_DELAY != 0) begin
                    state_n = ST_WAIT;
                    rcnt_n  = '0;
                end
            end
            ST_WAIT: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    rcnt_n  = '0;
                end else if (rcnt == RD_M1) begin
                    state_n = ST_REPEAT;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    rcnt_n  = '0;
                end else if (rcnt == RP_M1) begin
                    rcnt_n = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                rcnt_n  = '0;
            end
        endcase
    end

    // a falling level always wins over a coincident repeat strobe
    always_comb begin
        rep_fire  = !fall && (((state == ST_WAIT) && (rcnt == RD_M1)) ||
                              ((state == ST_REPEAT) && (rcnt == RP_M1)));
        press_nxt = rise || rep_fire;
        rel_nxt   = fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end
endmodule

module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    logic [NUM_BTN-1:0] level_v, press_v, rel_v, press_nxt_v;
    logic               any_q;

    button_conditioner_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_lane [NUM_BTN-1:0] (
        .clk       (clk),
        .reset     (reset),
        .raw       (bus.btn_raw),
        .level     (level_v),
        .press     (press_v),
        .rel       (rel_v),
        .press_nxt (press_nxt_v)
    );

    always_ff @(posedge clk) begin
        if (reset) any_q <= 1'b0;
        else       any_q <= |press_nxt_v;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = rel_v;
    assign bus.any_press   = any_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Random and directed stimulus against an event-time reference model of the conditioner.
module tb_button_conditioner;
    localparam int NB = 4, D = 4, RD = 10, RP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(NB)) bif ();
    button_conditioner_if #(.NUM_BTN(NB)) bif0 ();
    assign bif0.btn_raw = bif.btn_raw;

    button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut (.clk(clk), .reset(reset), .bus(bif));
    button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP))
        dut0 (.clk(clk), .reset(reset), .bus(bif0));

    int n_cmp = 0, n_err = 0;
    int ecnt = -1;

    // model: pipeline of raw samples, mismatch run lengths, time of last accepted press
    logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    int            m_run [NB];
    int            m_ptime [NB];
    logic [NB-1:0] e_lvl = '0, e_press = '0, e_rel = '0, e_press0 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got=%0h exp=%0h", tag, ecnt, got, exp);
        end
    endtask

    task automatic model_step(input logic [NB-1:0] r, input logic rs);
        ecnt++;
        if (rs) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            e_lvl = '0; e_press = '0; e_rel = '0; e_press0 = '0;
            for (int b = 0; b < NB; b++) begin m_run[b] = 0; m_ptime[b] = 0; end
        end else begin
            for (int b = 0; b < NB; b++) begin
                logic rise, fall, rep;
                int   dt;
                rise = 1'b0; fall = 1'b0;
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                        rise = m_lvl[b];
                        fall = !m_lvl[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                if (rise) m_ptime[b] = ecnt;
                dt  = ecnt - m_ptime[b];
                rep = m_lvl[b] && !rise && dt >= RD && ((dt - RD) % RP) == 0;
                e_press[b]  = rise || rep;
                e_press0[b] = rise;
                e_rel[b]    = fall;
                e_lvl[b]    = m_lvl[b];
            end
            m_s2 = m_s1;
            m_s1 = r;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(bif.btn_raw, reset);
        @(negedge clk);
        chk("level",   bif.btn_level,   e_lvl);
        chk("press",   bif.btn_press,   e_press);
        chk("release", bif.btn_release, e_rel);
        chk("any",     bif.any_press,   |e_press);
        chk("press_rd0", bif0.btn_press, e_press0);
    endtask

    task automatic idle(input int n);
        bif.btn_raw = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int q[$];
        int exp_s3[8] = '{5, 15, 18, 21, 24, 27, 30, 33};
        int rel_at, cnt0, first_after;

        bif.btn_raw = '0;
        for (int b = 0; b < NB; b++) begin m_run[b] = 0; m_ptime[b] = 0; end
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        idle(5);

        // scenario 1: clean press, first press strobe in cycle 5
        q.delete();
        for (int i = 0; i < 12; i++) begin
            bif.btn_raw = 4'b0001;
            tick();
            if (bif.btn_press[0]) q.push_back(i);
        end
        chk("s1_npress", q.size(), 1);
        if (q.size() > 0) chk("s1_cycle", q[0], 5);
        idle(20);

        // scenario 2: 1- and 3-cycle glitches never qualify
        cnt0 = 0;
        for (int i = 0; i < 30; i++) begin
            bif.btn_raw = ((i == 0) || (i >= 12 && i < 15)) ? 4'b0001 : 4'b0000;
            tick();
            cnt0 += int'(bif.btn_press[0]) + int'(bif.btn_release[0]) + int'(bif.btn_level[0]);
        end
        chk("s2_glitch", cnt0, 0);

        // scenario 3 (and 4 on the REPEAT_DELAY=0 instance): hold edges 0..29
        q.delete(); rel_at = -1; cnt0 = 0;
        for (int i = 0; i < 45; i++) begin
            bif.btn_raw = (i < 30) ? 4'b0001 : 4'b0000;
            tick();
            if (bif.btn_press[0]) q.push_back(i);
            if (bif.btn_release[0]) rel_at = i;
            if (bif0.btn_press[0]) cnt0++;
        end
        chk("s3_npress", q.size(), 8);
        for (int k = 0; k < 8 && k < q.size(); k++) chk("s3_press_cycle", q[k], exp_s3[k]);
        chk("s3_release", rel_at, 35);
        chk("s4_rd0_npress", cnt0, 1);
        idle(10);

        // scenario 5: staggered starts on all buttons
        for (int i = 0; i < 25; i++) begin
            for (int b = 0; b < NB; b++) bif.btn_raw[b] = (i >= b);
            tick();
        end
        idle(15);

        // scenario 6: reset sampled at edge 20 while held
        first_after = -1;
        for (int i = 0; i < 35; i++) begin
            bif.btn_raw = 4'b0001;
            reset = (i == 20);
            tick();
            if (i == 21) chk("s6_zero", {bif.btn_level, bif.btn_press, bif.btn_release, 3'b0, bif.any_press}, 0);
            if (i > 20 && bif.btn_press[0] && first_after < 0) first_after = i;
        end
        reset = 1'b0;
        chk("s6_press", first_after, 26);
        idle(15);

        // random: slow toggling so some changes survive the debounce, rare resets
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(7) == 0) bif.btn_raw[b] = ~bif.btn_raw[b];
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
